// File: rtl/ram_result_writer_if.sv
// rtl/ram_result_writer_if.sv - control, result-stream and RAM-write bundle of ram_result_writer
//
// Groups every non-clock/reset signal of the writer.
//   start          frame arm request (sampled in IDLE only)
//   data_in        DEPTH packed PE_DATA_WIDTH signed result lanes, lane k at [k*PE_DATA_WIDTH +: PE_DATA_WIDTH]
//   data_in_valid  data_in holds a block
//   in_ready       writer accepts a block this cycle
//   ram_address    registered write address
//   ram_data       registered clamped pixel
//   ram_wren       registered write enable
//   busy           writer not idle
//   done           one-cycle end-of-frame pulse
//   sat_count      lanes clamped in the current frame
// master: producer/RAM side (drives start/data_in/data_in_valid); slave: the writer.
interface ram_result_writer_if #(
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int PE_DATA_WIDTH  = 16,
  parameter int DEPTH          = 4
);
  logic                               start;
  logic [PE_DATA_WIDTH*DEPTH-1:0]     data_in;
  logic                               data_in_valid;
  logic                               in_ready;
  logic [RAM_ADDR_WIDTH-1:0]          ram_address;
  logic [RAM_DATA_WIDTH-1:0]          ram_data;
  logic                               ram_wren;
  logic                               busy;
  logic                               done;
  logic [RAM_ADDR_WIDTH:0]            sat_count;

  modport master (
    output start, data_in, data_in_valid,
    input  in_ready, ram_address, ram_data, ram_wren, busy, done, sat_count
  );

  modport slave (
    input  start, data_in, data_in_valid,
    output in_ready, ram_address, ram_data, ram_wren, busy, done, sat_count
  );
endinterface

// File: rtl/ram_result_writer.sv
// rtl/ram_result_writer.sv - clamps DEPTH-lane result blocks to pixels and writes them sequentially to the output RAM
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    ram_result_writer_if.slave (start, data_in stream, RAM write port, status)
// One block is accepted in ARMED, then its DEPTH lanes are written one per cycle.
// Lane 0 is registered straight from data_in on the handshake edge so a block
// costs DEPTH write cycles plus one ARMED cycle. After the block ending at the
// top address the writer pulses done and returns to IDLE.
module ram_result_writer #(
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int PE_DATA_WIDTH  = 16,
  parameter int DEPTH          = 4
) (
  input  logic               clk,
  input  logic               reset,
  ram_result_writer_if.slave bus
);

  localparam int LCW  = $clog2(DEPTH) + 1;
  localparam int LIW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_BASE = RAM_ADDR_WIDTH'(2**RAM_ADDR_WIDTH - DEPTH);
  localparam logic [PE_DATA_WIDTH-1:0]  PIX_MAX   = PE_DATA_WIDTH'(2**RAM_DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE_ST} state_t;

  state_t state, state_next;

  logic [PE_DATA_WIDTH-1:0]  lane_buf [DEPTH];
  logic [LCW-1:0]            lane_cnt;
  logic [RAM_ADDR_WIDTH-1:0] base_addr;
  logic [RAM_ADDR_WIDTH-1:0] ram_address_q;
  logic [RAM_DATA_WIDTH-1:0] ram_data_q;
  logic                      ram_wren_q;
  logic [RAM_ADDR_WIDTH:0]   sat_count_q;

  logic                      arm;
  logic                      handshake;
  logic                      present;
  logic                      block_end;
  logic [PE_DATA_WIDTH-1:0]  cur_lane;
  logic [RAM_DATA_WIDTH-1:0] pix;
  logic                      sat;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // lane_cnt counts lanes already presented; reaching DEPTH closes the block.
  always_comb begin
    state_next = state;
    arm        = 1'b0;
    handshake  = 1'b0;
    present    = 1'b0;
    block_end  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          arm        = 1'b1;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (bus.data_in_valid) begin
          handshake  = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (lane_cnt == LCW'(DEPTH)) begin
          block_end  = 1'b1;
          state_next = (base_addr == LAST_BASE) ? DONE_ST : ARMED;
        end else begin
          present = 1'b1;
        end
      end
      DONE_ST: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // On the handshake edge the buffer is still being loaded, so lane 0 comes from data_in.
  always_comb begin
    cur_lane = handshake ? bus.data_in[PE_DATA_WIDTH-1:0] : lane_buf[lane_cnt[LIW-1:0]];
  end

  // Signed lane: sign bit set means negative -> 0; positive above pixel range -> full scale.
  always_comb begin
    pix = cur_lane[RAM_DATA_WIDTH-1:0];
    sat = 1'b0;
    if (cur_lane[PE_DATA_WIDTH-1]) begin
      pix = '0;
      sat = 1'b1;
    end else if (cur_lane > PIX_MAX) begin
      pix = '1;
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) lane_buf[k] <= '0;
      lane_cnt      <= '0;
      base_addr     <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      sat_count_q   <= '0;
    end else begin
      ram_wren_q <= 1'b0;
      if (arm) begin
        base_addr   <= '0;
        lane_cnt    <= '0;
        sat_count_q <= '0;
      end
      if (handshake) begin
        for (int k = 0; k < DEPTH; k++)
          lane_buf[k] <= bus.data_in[k*PE_DATA_WIDTH +: PE_DATA_WIDTH];
      end
      if (handshake || present) begin
        ram_wren_q    <= 1'b1;
        ram_address_q <= base_addr + RAM_ADDR_WIDTH'(lane_cnt);
        ram_data_q    <= pix;
        lane_cnt      <= lane_cnt + LCW'(1);
        if (sat) sat_count_q <= sat_count_q + 1'b1;
      end
      if (block_end) begin
        base_addr <= base_addr + RAM_ADDR_WIDTH'(DEPTH);
        lane_cnt  <= '0;
      end
    end
  end

  assign bus.in_ready    = (state == ARMED);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE_ST);
  assign bus.ram_address = ram_address_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.ram_wren    = ram_wren_q;
  assign bus.sat_count   = sat_count_q;

endmodule

// File: doc/ram_result_writer.md
# ram_result_writer

Write-back end of the brightness-filter datapath: accepts DEPTH-lane result words from the systolic array, clamps each 16-bit lane to an 8-bit pixel, and writes them sequentially into the output RAM. It is the counterpart of the input loader, which reads 8-bit pixels and packs them into DEPTH×16-bit words. The writer streams one block per handshake until the RAM address space is filled, then signals completion.

## Interface
- RAM_ADDR_WIDTH, 6, output RAM address width (2**RAM_ADDR_WIDTH pixels per frame)
- RAM_DATA_WIDTH, 8, output pixel width
- PE_DATA_WIDTH, 16, width of one result lane, signed two's complement
- DEPTH, 4, lanes per result word; 2**RAM_ADDR_WIDTH is a multiple of DEPTH
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  arms the writer for a new frame; sampled only in IDLE
- data_in  in  PE_DATA_WIDTH*DEPTH  result block; lane k = data_in[k*PE_DATA_WIDTH +: PE_DATA_WIDTH]
- data_in_valid  in  1  data_in holds a valid block
- in_ready  out  1  writer can accept a block this cycle
- ram_address  out  RAM_ADDR_WIDTH  registered write address
- ram_data  out  RAM_DATA_WIDTH  registered clamped pixel
- ram_wren  out  1  registered write enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last pixel of frame is written
- sat_count  out  RAM_ADDR_WIDTH+1  number of lanes clamped in the current frame

## Operation
- States: IDLE, ARMED, WRITE, DONE_ST.
- IDLE: in_ready=0. start=1 → ARMED; base_addr←0, lane_cnt←0, sat_count←0.
- ARMED: in_ready=1 (combinational from state). Handshake = data_in_valid && in_ready at a rising edge: latch all DEPTH lanes into an internal buffer → WRITE. No handshake → stay.
- WRITE: one lane per cycle, lane_cnt 0..DEPTH-1. Each cycle registers ram_wren=1, ram_address=base_addr+lane_cnt, ram_data=clamp(lane[lane_cnt]). in_ready=0.
- After lane DEPTH-1: base_addr←base_addr+DEPTH (mod 2**RAM_ADDR_WIDTH). If the block just written ended at address 2**RAM_ADDR_WIDTH-1 → DONE_ST, else → ARMED.
- DONE_ST: done=1 for exactly one cycle → IDLE. No wrap-around write ever occurs; a new frame requires a new start.
- Clamp: lane < 0 → 0; lane > 2**RAM_DATA_WIDTH-1 → 2**RAM_DATA_WIDTH-1; else low RAM_DATA_WIDTH bits. Each clamped lane increments sat_count, which holds its value after done until the next accepted start.
- data_in_valid in IDLE, WRITE or DONE_ST: ignored, not buffered. start outside IDLE: ignored.
- data_in may change after handshake; buffered copy is used.

## Timing
- Reset (at rising edge with reset=1): state IDLE; in_ready=0, ram_wren=0, ram_address=0, ram_data=0, busy=0, done=0, sat_count=0; lane buffer cleared. Reset mid-WRITE aborts immediately: ram_wren=0 from the first cycle after the reset edge, no further writes.
- Handshake at edge E0 → ram_wren=1 with lane 0 during cycle E0..E1 (RAM writes at E1); lane k written at edge E(k+1); last lane at E(DEPTH).
- ram_wren=0 in every cycle where a lane is not being presented.
- After non-final block: state ARMED and in_ready=1 in the cycle following E(DEPTH); throughput one block per DEPTH+1 cycles.
- After final block: done=1 in the cycle following E(DEPTH); busy falls one cycle later.
- start→ARMED: in_ready=1 in the cycle after the edge sampling start.

## Test plan
- Single block: start, then data_in lanes {10,20,30,40} valid → writes 10@0, 20@1, 30@2, 40@3 on 4 consecutive edges; in_ready back to 1 one cycle after last write; sat_count=0.
- Clamping: lanes {-5 (0xFFFB), 300, 255, 0x8000} → ram_data 0, 255, 255, 0; sat_count=3.
- Backpressure: data_in_valid held high continuously with new block each accepted handshake → exactly one block accepted per DEPTH+1 cycles, none lost or duplicated, addresses contiguous.
- Full frame: 16 blocks with lane value = address → 64 writes to 0..63 in order, done pulses once after write to 63, no write to address 0 afterwards, busy→0.
- Reset mid-WRITE after lane 1 → ram_wren=0 next cycle, lanes 2-3 never written, state IDLE, all outputs at reset values; following start+block writes from address 0.
- Spurious inputs: data_in_valid in IDLE and start during WRITE → no writes, no state change; frame continues at the correct base address.
